// File: rtl/eth_tx_arb.sv
// Round-robin scheduler sharing one eth_tx2 transmitter and its banked frame BRAM
// between NREQ producers; returns a per-requester done or err pulse for each grant.
module eth_tx_arb #(
  parameter int NREQ          = 2,
  parameter int START_TIMEOUT = 16,
  parameter int BW            = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clk_stb_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o,
  output logic [NREQ-1:0] done_o,
  output logic [NREQ-1:0] err_o,
  output logic            tx_start_o,
  input  logic            tx_busy_i,
  output logic [BW-1:0]   bank_sel_o,
  output logic [15:0]     frames_sent_o
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    SENDING = 2'd2
  } state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] err_q;
  logic            tx_start_q;
  logic [BW-1:0]   bank_sel_q;
  logic [BW-1:0]   ptr_q;
  logic [TW-1:0]   cnt_q;
  logic [15:0]     frames_q;

  logic [BW:0]     cand_s;
  logic [BW-1:0]   sel_idx_s;
  logic            sel_vld_s;
  logic [BW-1:0]   ptr_d;
  logic [TW-1:0]   cnt_d;
  logic [15:0]     frames_d;

  // Scan from the highest offset down so the candidate closest to ptr_q is the last one kept.
  always_comb begin
    sel_vld_s = 1'b0;
    sel_idx_s = '0;
    cand_s    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s    = {1'b0, ptr_q} + (BW+1)'(k);
      cand_s    = (cand_s >= (BW+1)'(NREQ)) ? cand_s - (BW+1)'(NREQ) : cand_s;
      sel_vld_s = sel_vld_s | req_i[cand_s[BW-1:0]];
      sel_idx_s = req_i[cand_s[BW-1:0]] ? cand_s[BW-1:0] : sel_idx_s;
    end
  end

  // The owner's bank index doubles as its requester index, so the rotated pointer derives from it.
  assign ptr_d    = (bank_sel_q == BW'(NREQ - 1)) ? '0 : bank_sel_q + BW'(1);
  assign cnt_d    = cnt_q + TW'(1);
  assign frames_d = frames_q + 16'd1;

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      bank_sel_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      frames_q   <= 16'd0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (!tx_busy_i && sel_vld_s) begin
            grant_q    <= NREQ'(1) << sel_idx_s;
            bank_sel_q <= sel_idx_s;
            tx_start_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (tx_busy_i) begin
            tx_start_q <= 1'b0;
            state_q    <= SENDING;
          end else if (cnt_q == TW'(START_TIMEOUT)) begin
            err_q      <= grant_q;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            ptr_q      <= ptr_d;
            state_q    <= IDLE;
          end else if (clk_stb_i) begin
            cnt_q <= cnt_d;
          end
        end
        SENDING: begin
          tx_start_q <= 1'b0;
          if (!tx_busy_i) begin
            done_q   <= grant_q;
            grant_q  <= '0;
            frames_q <= frames_d;
            ptr_q    <= ptr_d;
            state_q  <= IDLE;
          end
        end
        default: begin
          grant_q    <= '0;
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign tx_start_o    = tx_start_q;
  assign bank_sel_o    = bank_sel_q;
  assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: stimulus queues expected grant/done/err events,
// an independent monitor pops and compares them whenever the DUT presents one.
module tb_eth_tx_arb;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    logic [1:0]  vec;
    logic        bank;
    logic [15:0] fr;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        clk_stb;
  logic [1:0]  req;
  logic        tx_busy;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        tx_start;
  logic [0:0]  bank_sel;
  logic [15:0] frames;

  int  checks;
  int  errors;
  ev_t exp_q[$];

  eth_tx_arb #(.NREQ(2), .START_TIMEOUT(16), .BW(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clk_stb_i    (clk_stb),
    .req_i        (req),
    .grant_o      (grant),
    .done_o       (done),
    .err_o        (err),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .bank_sel_o   (bank_sel),
    .frames_sent_o(frames)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle bit strobe every fourth clock
  initial begin
    clk_stb = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 clk_stb = 1'b1;
      @(posedge clk);
      #1 clk_stb = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [1:0] v, input logic b, input logic [15:0] f);
    ev_t e;
    e.kind = k;
    e.vec  = v;
    e.bank = b;
    e.fr   = f;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [1:0] v);
    ev_t  e;
    logic want_ts;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d vec=%b bank=%0d frames=%0h", k, v, bank_sel, frames);
    end else begin
      e       = exp_q.pop_front();
      want_ts = (k == K_GRANT);
      if (e.kind != k || e.vec !== v || e.bank !== bank_sel[0] || e.fr !== frames ||
          tx_start !== want_ts || (k != K_GRANT && grant !== 2'b00)) begin
        errors++;
        $display("FAIL event got kind=%0d vec=%b bank=%0d frames=%0h tx_start=%0d grant=%b want kind=%0d vec=%b bank=%0d frames=%0h tx_start=%0d",
                 k, v, bank_sel, frames, tx_start, grant, e.kind, e.vec, e.bank, e.fr, want_ts);
      end
    end
  endtask

  // Monitor: compares each presented event with the head of the scoreboard
  initial begin
    logic [1:0] prev_grant;
    prev_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if ($countones({grant, done, err}) > 1) begin
          errors++;
          $display("FAIL exclusive grant=%b done=%b err=%b want at most one bit", grant, done, err);
        end
        if (grant != 2'b00 && prev_grant == 2'b00) check_ev(K_GRANT, grant);
        if (done != 2'b00) check_ev(K_DONE, done);
        if (err != 2'b00) check_ev(K_ERR, err);
      end
      prev_grant = grant;
    end
  end

  // Transmitter model for one frame: busy rises one strobe after start and is held busy_clks.
  task automatic do_frame(input logic [1:0] req_mid, input logic [1:0] req_after,
                          input int busy_clks, input logic exp_bank);
    int n;
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", {31'd0, tx_start}, 32'd1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!clk_stb && n < 50);
    #1;
    chk("tx_start_until_busy", {31'd0, tx_start}, 32'd1);
    tx_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tx_start_drop", {31'd0, tx_start}, 32'd0);
    req = req_mid;
    repeat (busy_clks) @(posedge clk);
    #1;
    chk("bank_hold", {31'd0, bank_sel}, {31'd0, exp_bank});
    tx_busy = 1'b0;
    @(posedge clk);
    #1 req = req_after;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int stbs;
    logic s;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    req     = 2'b00;
    tx_busy = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_done_err", {28'd0, done, err}, 32'd0);
    chk("rst_bank_frames", {15'd0, bank_sel, frames}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request, long frame
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd0);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd1);
    req = 2'b01;
    do_frame(2'b01, 2'b00, 1000, 1'b0);
    repeat (3) @(negedge clk);

    // Contention from a fresh pointer: 0,1,0,1
    pulse_reset();
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd0);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd1);
    expect_ev(K_GRANT, 2'b10, 1'b1, 16'd1);
    expect_ev(K_DONE,  2'b10, 1'b1, 16'd2);
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd2);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd3);
    expect_ev(K_GRANT, 2'b10, 1'b1, 16'd3);
    expect_ev(K_DONE,  2'b10, 1'b1, 16'd4);
    req = 2'b11;
    do_frame(2'b11, 2'b11, 20, 1'b0);
    do_frame(2'b11, 2'b11, 20, 1'b1);
    do_frame(2'b11, 2'b11, 20, 1'b0);
    do_frame(2'b11, 2'b00, 20, 1'b1);
    repeat (3) @(negedge clk);
    chk("contention_frames", {16'd0, frames}, 32'd4);

    // Start timeout on requester 1
    expect_ev(K_GRANT, 2'b10, 1'b1, 16'd4);
    expect_ev(K_ERR,   2'b10, 1'b1, 16'd4);
    req = 2'b10;
    n = 0;
    while (grant == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    stbs = 0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      s = clk_stb;
      @(negedge clk);
      n++;
      if (err != 2'b00) break;
      stbs += int'(s);
    end
    req = 2'b00;
    chk("timeout_strobes", stbs, 32'd16);
    @(negedge clk);
    chk("timeout_idle", {29'd0, grant, tx_start}, 32'd0);

    // After the timeout the rotated pointer favours requester 0
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd4);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd5);
    req = 2'b11;
    do_frame(2'b11, 2'b00, 10, 1'b0);
    repeat (3) @(negedge clk);

    // Transmitter busy while idle blocks the grant
    tx_busy = 1'b1;
    req     = 2'b01;
    repeat (10) @(negedge clk);
    chk("busy_idle_no_grant", {30'd0, grant}, 32'd0);
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd5);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd6);
    @(posedge clk);
    #1 tx_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("grant_after_busy", {30'd0, grant}, 32'd1);
    do_frame(2'b01, 2'b00, 10, 1'b0);
    repeat (3) @(negedge clk);

    // Request withdrawn mid-frame
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd6);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd7);
    req = 2'b01;
    do_frame(2'b00, 2'b00, 8, 1'b0);
    repeat (3) @(negedge clk);

    // Asynchronous reset while sending
    expect_ev(K_GRANT, 2'b10, 1'b1, 16'd7);
    req = 2'b10;
    n = 0;
    while (!tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_grant", {30'd0, grant}, 32'd0);
    chk("areset_tx_start", {31'd0, tx_start}, 32'd0);
    chk("areset_done_err", {28'd0, done, err}, 32'd0);
    chk("areset_bank_frames", {15'd0, bank_sel, frames}, 32'd0);
    req = 2'b01;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_busy_no_grant", {30'd0, grant}, 32'd0);
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'd0);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'd1);
    @(posedge clk);
    #1 tx_busy = 1'b0;
    do_frame(2'b01, 2'b00, 5, 1'b0);
    repeat (3) @(negedge clk);

    // Counter wrap
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    @(negedge clk);
    chk("wrap_preload", {16'd0, frames}, 32'h0000FFFF);
    expect_ev(K_GRANT, 2'b01, 1'b0, 16'hFFFF);
    expect_ev(K_DONE,  2'b01, 1'b0, 16'h0000);
    req = 2'b01;
    do_frame(2'b01, 2'b00, 5, 1'b0);
    repeat (5) @(negedge clk);
    chk("wrap_frames", {16'd0, frames}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
